// File: rtl/push_cfg_consumer.sv
// push_cfg_consumer
//   Consumer end of the push-button handshake for the RTC configuration path.
//   Serves one sticky debouncer flag at a time (priority up > down > left > right),
//   applies the matching edit to the hour/minute/second registers and returns a
//   one-cycle listo_* clear pulse to the flag's debouncer. If the flag fails to
//   drop, listo is re-issued after RETRY_CYC cycles without re-applying the edit.
//
//   Optional feature macro: CFG_12H_EN -> hr range 1..12, reset value 12.
//   Default build: 24-hour range 0..23, reset value 0.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   push_up/down/left/right       sticky flags from the debouncers
//   cfg_en                        edit enable (flags are acknowledged either way)
//   listo_up/down/left/right      registered one-cycle clear pulses
//   cursor [1:0]                  selected field: 0 sec, 1 min, 2 hr
//   hr [4:0], min [5:0], sec [5:0] configuration values
//   cfg_write                     one-cycle strobe when a field value changes
//   busy                          FSM not in IDLE
module push_cfg_consumer #(
   parameter int RETRY_CYC = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_up,
   input  logic       push_down,
   input  logic       push_left,
   input  logic       push_right,
   input  logic       cfg_en,
   output logic       listo_up,
   output logic       listo_down,
   output logic       listo_left,
   output logic       listo_right,
   output logic [1:0] cursor,
   output logic [4:0] hr,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       cfg_write,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;
   typedef enum logic [1:0] {B_UP, B_DOWN, B_LEFT, B_RIGHT} btn_t;

`ifdef CFG_12H_EN
   localparam logic [5:0] HR_LO  = 6'd1;
   localparam logic [5:0] HR_HI  = 6'd12;
   localparam logic [4:0] HR_RST = 5'd12;
`else
   localparam logic [5:0] HR_LO  = 6'd0;
   localparam logic [5:0] HR_HI  = 6'd23;
   localparam logic [4:0] HR_RST = 5'd0;
`endif
   localparam logic [5:0] MS_HI  = 6'd59;
   localparam logic [3:0] CNT_LAST = 4'(RETRY_CYC - 1);

   // Compare-and-load wrap: anything at/above the top (or outside the range)
   // reloads the opposite bound, so an illegal value can never persist.
   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] lo,
                                           input logic [5:0] hi);
      return (v >= hi || v < lo) ? lo : v + 6'd1;
   endfunction

   function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] lo,
                                           input logic [5:0] hi);
      return (v <= lo || v > hi) ? hi : v - 6'd1;
   endfunction

   state_t     state, state_n;
   btn_t       served, served_n, pick;
   logic [3:0] cnt, cnt_n;
   logic [3:0] listo_q, listo_n;
   logic       cfg_write_n;
   logic [1:0] cursor_n;
   logic [4:0] hr_n;
   logic [5:0] min_n, sec_n;
   logic [3:0] flags;

   assign flags = {push_right, push_left, push_down, push_up};

   always_comb begin
      state_n     = state;
      served_n    = served;
      cnt_n       = cnt;
      listo_n     = '0;
      cfg_write_n = 1'b0;
      cursor_n    = cursor;
      hr_n        = hr;
      min_n       = min;
      sec_n       = sec;
      pick        = B_UP;

      if (push_up)        pick = B_UP;
      else if (push_down) pick = B_DOWN;
      else if (push_left) pick = B_LEFT;
      else                pick = B_RIGHT;

      case (state)
         IDLE: begin
            if (|flags) begin
               state_n       = ACK;
               served_n      = pick;
               listo_n[pick] = 1'b1;
               if (cfg_en) begin
                  case (pick)
                     B_UP, B_DOWN: begin
                        cfg_write_n = 1'b1;
                        case (cursor)
                           2'd0: sec_n = (pick == B_UP) ? wrap_inc(sec, 6'd0, MS_HI)
                                                        : wrap_dec(sec, 6'd0, MS_HI);
                           2'd1: min_n = (pick == B_UP) ? wrap_inc(min, 6'd0, MS_HI)
                                                        : wrap_dec(min, 6'd0, MS_HI);
                           default: hr_n = 5'((pick == B_UP) ? wrap_inc({1'b0, hr}, HR_LO, HR_HI)
                                                             : wrap_dec({1'b0, hr}, HR_LO, HR_HI));
                        endcase
                     end
                     B_LEFT:  cursor_n = (cursor >= 2'd2) ? 2'd0 : cursor + 2'd1;
                     default: cursor_n = (cursor == 2'd0 || cursor > 2'd2) ? 2'd2 : cursor - 2'd1;
                  endcase
               end
            end
         end
         ACK: begin
            state_n = WAIT_CLR;
            cnt_n   = '0;
         end
         WAIT_CLR: begin
            if (!flags[served]) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 4'd1;
               // Debouncer missed the clear: re-issue listo, edit is not repeated.
               if (cnt == CNT_LAST) begin
                  state_n         = ACK;
                  listo_n[served] = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         served    <= B_UP;
         cnt       <= '0;
         listo_q   <= '0;
         cfg_write <= 1'b0;
         cursor    <= 2'd0;
         hr        <= HR_RST;
         min       <= 6'd0;
         sec       <= 6'd0;
      end else begin
         state     <= state_n;
         served    <= served_n;
         cnt       <= cnt_n;
         listo_q   <= listo_n;
         cfg_write <= cfg_write_n;
         cursor    <= cursor_n;
         hr        <= hr_n;
         min       <= min_n;
         sec       <= sec_n;
      end
   end

   assign {listo_right, listo_left, listo_down, listo_up} = listo_q;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_push_cfg_consumer.sv
module tb_push_cfg_consumer;

   localparam int RC = 4;
`ifdef CFG_12H_EN
   localparam int HR_RST = 12;
`else
   localparam int HR_RST = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       push_up = 0, push_down = 0, push_left = 0, push_right = 0;
   logic       cfg_en = 0;
   logic       listo_up, listo_down, listo_left, listo_right;
   logic [1:0] cursor;
   logic [4:0] hr;
   logic [5:0] min, sec;
   logic       cfg_write, busy;

   push_cfg_consumer #(.RETRY_CYC(RC)) dut (
      .clk(clk), .rst_n(rst_n),
      .push_up(push_up), .push_down(push_down), .push_left(push_left), .push_right(push_right),
      .cfg_en(cfg_en),
      .listo_up(listo_up), .listo_down(listo_down), .listo_left(listo_left), .listo_right(listo_right),
      .cursor(cursor), .hr(hr), .min(min), .sec(sec),
      .cfg_write(cfg_write), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   bit hold = 0;                       // debouncer model ignores listo when set
   int m_sec = 0, m_min = 0, m_hr = HR_RST, m_cur = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lv();
      return int'({listo_right, listo_left, listo_down, listo_up});
   endfunction

   function automatic int hr_up(input int h);
`ifdef CFG_12H_EN
      return h % 12 + 1;
`else
      return (h + 1) % 24;
`endif
   endfunction

   function automatic int hr_dn(input int h);
`ifdef CFG_12H_EN
      return (h + 10) % 12 + 1;
`else
      return (h + 23) % 24;
`endif
   endfunction

   // Reference: effect of serving button b (0 up, 1 down, 2 left, 3 right)
   task automatic model_apply(input int b, input bit en);
      if (en) begin
         case (b)
            0: case (m_cur) 0: m_sec = (m_sec + 1) % 60; 1: m_min = (m_min + 1) % 60; default: m_hr = hr_up(m_hr); endcase
            1: case (m_cur) 0: m_sec = (m_sec + 59) % 60; 1: m_min = (m_min + 59) % 60; default: m_hr = hr_dn(m_hr); endcase
            2: m_cur = (m_cur + 1) % 3;
            default: m_cur = (m_cur + 2) % 3;
         endcase
      end
   endtask

   task automatic model_reset();
      m_sec = 0; m_min = 0; m_hr = HR_RST; m_cur = 0;
   endtask

   task automatic set_flag(input int b);
      case (b)
         0: push_up = 1'b1;
         1: push_down = 1'b1;
         2: push_left = 1'b1;
         default: push_right = 1'b1;
      endcase
   endtask

   // One clock; the debouncer model clears a flag on the edge where its listo is high.
   task automatic tick();
      int l;
      l = lv();
      @(posedge clk);
      #1;
      if (!hold) begin
         if (l[0]) push_up = 1'b0;
         if (l[1]) push_down = 1'b0;
         if (l[2]) push_left = 1'b0;
         if (l[3]) push_right = 1'b0;
      end
      chk("listo_onehot", int'($countones(lv()) <= 1), 1);
   endtask

   task automatic chk_fields(input string tag);
      chk({tag, "_sec"}, int'(sec), m_sec);
      chk({tag, "_min"}, int'(min), m_min);
      chk({tag, "_hr"}, int'(hr), m_hr);
      chk({tag, "_cursor"}, int'(cursor), m_cur);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_listo"}, lv(), 0);
      chk({tag, "_cfg_write"}, int'(cfg_write), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk_fields(tag);
   endtask

   task automatic press(input int b, input bit en);
      cfg_en = en;
      set_flag(b);
      model_apply(b, en);
      tick();
      chk("press_listo", lv(), 1 << b);
      chk("press_cfg_write", int'(cfg_write), int'(en && b < 2));
      chk("press_busy", int'(busy), 1);
      chk_fields("press");
      tick();
      chk("press_listo_e1", lv(), 0);
      chk("press_cfg_write_e1", int'(cfg_write), 0);
      chk("press_busy_e1", int'(busy), 1);
      tick();
      chk("press_busy_e2", int'(busy), 0);
   endtask

   initial begin
      model_reset();
      #12;
      chk_reset_outputs("rst_held");
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      chk_reset_outputs("rst_rel");

      // basic increment, then boundaries on seconds
      press(0, 1'b1);                    // sec 0 -> 1
      press(1, 1'b1);                    // 1 -> 0
      press(1, 1'b1);                    // 0 -> 59
      press(0, 1'b1);                    // 59 -> 0
      // cursor wrap 0 -> 2, hour boundaries
      press(3, 1'b1);
      press(1, 1'b1);
      press(0, 1'b1);
      press(0, 1'b1);
      press(1, 1'b1);
      press(2, 1'b1);                    // cursor 2 -> 0

      // simultaneous up + right: up first, right three cycles later
      cfg_en = 1'b1;
      push_up = 1'b1; push_right = 1'b1;
      model_apply(0, 1'b1);
      tick();
      chk("prio_first", lv(), 1);
      chk_fields("prio_first");
      tick();
      chk("prio_gap1", lv(), 0);
      tick();
      chk("prio_gap2", lv(), 0);
      model_apply(3, 1'b1);
      tick();
      chk("prio_second", lv(), 8);
      chk("prio_cfg_write", int'(cfg_write), 0);
      chk_fields("prio_second");
      tick(); tick();
      chk("prio_busy", int'(busy), 0);
      chk("prio_cursor_end", int'(cursor), 2);

      // flag stuck high: listo every RC+1 cycles, edit exactly once
      hold = 1'b1;
      cfg_en = 1'b1;
      set_flag(1);
      model_apply(1, 1'b1);
      for (int k = 0; k <= 2 * (RC + 1); k++) begin
         tick();
         chk("retry_listo", lv(), (k % (RC + 1) == 0) ? 2 : 0);
         chk("retry_cfg_write", int'(cfg_write), int'(k == 0));
         chk("retry_busy", int'(busy), 1);
         chk_fields("retry");
      end
      hold = 1'b0;
      tick(); tick();
      chk("retry_busy_end", int'(busy), 0);
      chk_fields("retry_end");

      // edits disabled: acknowledged, nothing changes
      press(1, 1'b0);
      press(2, 1'b0);

      // reset while waiting for the clear; pending flag served afterwards
      hold = 1'b1;
      cfg_en = 1'b1;
      set_flag(2);
      model_apply(2, 1'b1);
      tick();
      chk("mid_listo", lv(), 4);
      chk_fields("mid");
      tick();
      chk("mid_wait_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_reset_outputs("mid_rst");
      chk("mid_flag_kept", int'(push_left), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      hold = 1'b0;
      model_apply(2, 1'b1);
      tick();
      chk("post_rst_listo", lv(), 4);
      chk_fields("post_rst");
      tick(); tick();
      chk("post_rst_busy", int'(busy), 0);

      // random single-press traffic
      for (int i = 0; i < 40; i++) begin
         int b, gap;
         bit en;
         b = int'($urandom_range(3));
         en = ($urandom_range(3) != 0);
         press(b, en);
         gap = int'($urandom_range(2));
         for (int g = 0; g < gap; g++) tick();
      end
      chk_fields("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/push_cfg_consumer.md
# push_cfg_consumer

Consumer end of the push-button handshake for the RTC configuration path. Samples the four sticky push flags produced by the debounced button front-ends, serves one flag at a time, applies the matching edit to the hour/minute/second configuration registers and returns a one-cycle `listo_*` clear pulse to the flag's debouncer. Sits between the button front-ends and the RTC write logic. `cfg_write` tells the RTC writer that new field values are ready.

## Interface
- `RETRY_CYC`, default 4: cycles in WAIT_CLR with the served flag still high before `listo` is re-issued. Range 2–15.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `push_up`, `push_down`, `push_left`, `push_right` in 1 each: sticky flags from the debouncers. Each stays high until its `listo` clear.
- `cfg_en` in 1: edit enable. When low, flags are still acknowledged but no field changes.
- `listo_up`, `listo_down`, `listo_left`, `listo_right` out 1 each: one-cycle clear pulses, registered.
- `cursor` out 2: selected field. 0 = seconds, 1 = minutes, 2 = hours. Value 3 never occurs.
- `hr` out 5, `min` out 6, `sec` out 6: binary configuration values.
- `cfg_write` out 1: one-cycle strobe, high in the cycle the field values change.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Reset values:
  - All `listo_*` = 0, `cfg_write` = 0, `busy` = 0.
  - `cursor` = 0, `min` = 0, `sec` = 0.
  - `hr` = 0, or 12 with CFG_12H_EN.
  - FSM in IDLE, retry counter = 0.
- FSM states: IDLE, ACK, WAIT_CLR.
- **IDLE**
  - If any flag is high, latch the served button and go to ACK.
  - Fixed priority: up > down > left > right. Lower-priority flags stay pending.
  - The edit is applied on the same edge.
- **Edits** (only when `cfg_en` = 1):
  - up: selected field +1, with wrap. `sec` and `min` go 59→0; `hr` goes 23→0.
  - down: selected field −1. `sec` and `min` go 0→59; `hr` goes 0→23.
  - left: `cursor` +1, wrapping 2→0.
  - right: `cursor` −1, wrapping 0→2.
  - `cfg_write` pulses only for up/down with `cfg_en` = 1. Cursor moves do not pulse it.
- **ACK**
  - The served `listo_*` is high for exactly this cycle.
  - Next state is always WAIT_CLR; the retry counter is cleared.
- **WAIT_CLR**
  - If the served flag is low, go to IDLE.
  - Otherwise increment the counter. When it reaches RETRY_CYC, go back to ACK to re-issue `listo`, without re-applying the edit.
- **Simultaneous events**
  - Only one `listo_*` is ever high in a cycle.
  - A flag that rises while another is being served waits in its debouncer and is served in a later IDLE.
- Out-of-range values on a field cannot be produced. Arithmetic wraps by compare-and-load, never by modulo 2^n.
- `rst_n` asserted mid-handshake:
  - Immediate return to reset values.
  - The debouncer flag stays set and is served after reset release.

## Timing
- Flag sampled high at edge E0 in IDLE:
  - After E0: edit and `cfg_write` visible, `listo` high, `busy` high.
  - E1: `listo` low, state WAIT_CLR. The debouncer clears its flag on the same edge.
  - E2: flag seen low, state IDLE.
  - E3: earliest next acceptance. Sustained throughput is one event per 3 cycles.
- `busy` rises after E0 and falls after E2.
- Output-to-flag latency: the edit is visible 1 cycle after the flag is sampled.

## Configuration
- `CFG_12H_EN` defined:
  - `hr` range is 1..12. up wraps 12→1, down wraps 1→12.
  - Reset `hr` = 12.
- `CFG_12H_EN` undefined: 24-hour range 0..23 as described above.

## Test plan
- Reset, `cfg_en` = 1, cursor 0, pulse `push_up` (sticky, cleared by a debouncer model on `listo_up`) → `sec` = 1, one `cfg_write`, one `listo_up` 1 cycle after sampling, `busy` low after 3 cycles.
- `sec` = 59, up → `sec` = 0. `hr` = 0, cursor 2, down → `hr` = 23 (`hr` = 12 under CFG_12H_EN for the 1→12 case).
- `push_up` and `push_right` high on the same cycle → `listo_up` first, `listo_right` 3 cycles later, never overlapping; `cursor` ends at 2.
- Flag held high (model ignores `listo`), RETRY_CYC = 4 → `listo` re-pulses every 5 cycles, field changes exactly once.
- `cfg_en` = 0, `push_down` → `listo_down` issued, no `cfg_write`, fields unchanged.
- `rst_n` low during WAIT_CLR → all outputs at reset values immediately; the pending flag is served after release.
